fp_addsub_sched: RTL

- Round-robin scheduler that shares one single-precision (IEEE-754 layout) add/subtract datapath between N requesters.
- Accepts operand pairs over valid/ready request channels, presents the winner's operands to the shared combinational datapath, and holds them stable for DP_WAIT cycles.
- Captures the datapath result and returns it on one shared response channel, tagged with the requester id.
- Sits between the client blocks and the existing add/subtract datapath instances.

---
 rtl/fp_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/fp_addsub_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fp_sched_pkg.sv
// Shared types and helpers for the fp_addsub_sched slice: FSM state codes,
// operation encodings, single-precision field widths and zero detection.
package fp_sched_pkg;

    // FSM state codes
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Operation select on req_op / dp_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Single-precision field widths
    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

    // A value is zero when everything below the sign bit is clear (+0 or -0)
    function automatic logic is_fp_zero(input logic [FP_W-1:0] x);
        return (x[EXP_W+MANT_W-1:0] == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr, wraps from
// N-1 to 0, and the first asserted request wins. Grant is one-hot or zero.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant
);

    int unsigned idx;
    logic        found;

    // Scan requesters in rotated order and grant the first one found
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx[IDW-1:0]]) begin
                grant[idx[IDW-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one single-precision add/subtract datapath
// between N requesters. The winner's operands are registered onto dp_*, held
// for DP_WAIT cycles, and the sampled result is returned on a single response
// channel tagged with the requester id.
// Optional build macro FP_ZERO_BYPASS_EN: requests with a zero operand are
// answered directly (IDLE -> RESP) without touching dp_*.
module fp_addsub_sched
    import fp_sched_pkg::*;
#(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int DP_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [N-1:0]      req_op,
    input  logic [32*N-1:0]   req_a,
    input  logic [32*N-1:0]   req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_data,
    output logic [31:0]       dp_a,
    output logic [31:0]       dp_b,
    output logic              dp_op,
    input  logic [31:0]       dp_result,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam logic [3:0] WAIT_INIT = 4'(DP_WAIT);

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [3:0]     wait_cnt;
    logic [N-1:0]   grant;
    logic           hs;
    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] next_ptr;
    logic [31:0]    sel_a;
    logic [31:0]    sel_b;
    logic           sel_op;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    // Offer the grant only in IDLE and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst)
            req_ready = grant;
        hs = |(req_valid & req_ready);
    end

    // Decode the one-hot grant into an index, operands and the next pointer
    always_comb begin
        sel_idx = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_op  = OP_ADD;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                sel_idx = IDW'(k);
                sel_a   = req_a[32*k +: 32];
                sel_b   = req_b[32*k +: 32];
                sel_op  = req_op[k];
            end
        end
        next_ptr = (sel_idx == IDW'(N-1)) ? '0 : sel_idx + 1'b1;
    end

`ifdef FP_ZERO_BYPASS_EN
    logic        byp_hit;
    logic [31:0] byp_res;

    // Direct result when either operand is zero; subtracting flips b's sign
    always_comb begin
        byp_hit = is_fp_zero(sel_a) || is_fp_zero(sel_b);
        byp_res = sel_a;
        if (is_fp_zero(sel_a) && is_fp_zero(sel_b))
            byp_res = {sel_a[31] & (sel_b[31] ^ (sel_op == OP_SUB)), 31'b0};
        else if (is_fp_zero(sel_b))
            byp_res = sel_a;
        else
            byp_res = {sel_b[31] ^ (sel_op == OP_SUB), sel_b[30:0]};
    end
`endif

    assign busy = (state != IDLE);

    // Main FSM: grant, hold operands for DP_WAIT cycles, present the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_op     <= OP_ADD;
            op_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (hs) begin
                        rsp_id <= sel_idx;
                        ptr    <= next_ptr;
`ifdef FP_ZERO_BYPASS_EN
                        if (byp_hit) begin
                            rsp_data  <= byp_res;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            dp_a     <= sel_a;
                            dp_b     <= sel_b;
                            dp_op    <= sel_op;
                            wait_cnt <= WAIT_INIT;
                            state    <= EXEC;
                        end
`else
                        dp_a     <= sel_a;
                        dp_b     <= sel_b;
                        dp_op    <= sel_op;
                        wait_cnt <= WAIT_INIT;
                        state    <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    if (wait_cnt == 4'd1) begin
                        rsp_data  <= dp_result;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
